// File: rtl/umstr_axis_arb_pkg.sv
// Shared types and helpers for the multi-source AXI-Stream arbiter.
// Holds the FSM state enum and the round-robin pick function.
package umstr_arb_pkg;

    localparam int unsigned MAX_SRC = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // First set request at or above ptr, wrapping at n sources.
    // Returns ptr when nothing is requesting.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        logic [2:0] sel;
        logic [2:0] idx;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            idx = 3'((32'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/umstr_axis_arb_if.sv
// AXI-Stream bundle used between the arbiter core and its output stage.
// master drives payload/valid, slave drives ready.
interface umstr_axis_arb_if #(
    parameter int DW = 32,
    parameter int KW = 4
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [KW-1:0] tkeep;

    modport master (
        output tdata, tvalid, tlast, tkeep,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tkeep,
        output tready
    );
endinterface

// File: rtl/umstr_axis_arb_skid.sv
// Two-entry output buffer: full throughput with a registered upstream
// ready, so downstream ready never reaches the sources combinationally.
module umstr_axis_arb_skid #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    umstr_axis_arb_if.slave       s,
    umstr_axis_arb_if.master      m
);

    logic [1:0]    cnt_q, cnt_d;
    logic          wr_q, rd_q;
    logic [DW-1:0] dat_q  [2];
    logic [KW-1:0] keep_q [2];
    logic          last_q [2];
    logic          push, pop;

    assign s.tready = (cnt_q != 2'd2);
    assign m.tvalid = (cnt_q != 2'd0);
    assign m.tdata  = dat_q[rd_q];
    assign m.tkeep  = keep_q[rd_q];
    assign m.tlast  = last_q[rd_q];

    assign push = s.tvalid & s.tready;
    assign pop  = m.tvalid & m.tready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Occupancy and pointers; reset empties both entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
        end
    end

    // Payload storage, written on accepted input beats only.
    always_ff @(posedge clk) begin
        if (push) begin
            dat_q[wr_q]  <= s.tdata;
            keep_q[wr_q] <= s.tkeep;
            last_q[wr_q] <= s.tlast;
        end
    end

endmodule

// File: rtl/umstr_axis_arb.sv
// Packet-level round-robin arbiter merging N AXI-Stream sources.
// A granted source owns the output until its tlast beat is accepted.
module umstr_axis_arb
    import umstr_arb_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int T_DATA_WIDTH = 32,
    parameter int T_KEEP_WIDTH = 4,
    localparam int GW          = $clog2(N_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_SRC*T_DATA_WIDTH-1:0] s_tdata_i,
    input  logic [N_SRC-1:0]              s_tvalid_i,
    input  logic [N_SRC-1:0]              s_tlast_i,
    input  logic [N_SRC*T_KEEP_WIDTH-1:0] s_tkeep_i,
    output logic [N_SRC-1:0]              s_tready_o,
    output logic [T_DATA_WIDTH-1:0]       m_tdata_o,
    output logic                          m_tvalid_o,
    output logic                          m_tlast_o,
    output logic [T_KEEP_WIDTH-1:0]       m_tkeep_o,
    input  logic                          m_tready_i,
    output logic [GW-1:0]                 grant_o,
    output logic                          busy_o
);

    arb_state_e           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [MAX_SRC-1:0]   req_pad;

    umstr_axis_arb_if #(.DW(T_DATA_WIDTH), .KW(T_KEEP_WIDTH)) arb_s ();
    umstr_axis_arb_if #(.DW(T_DATA_WIDTH), .KW(T_KEEP_WIDTH)) out_s ();

    umstr_axis_arb_skid #(
        .DW (T_DATA_WIDTH),
        .KW (T_KEEP_WIDTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .s     (arb_s.slave),
        .m     (out_s.master)
    );

    assign m_tdata_o    = out_s.tdata;
    assign m_tvalid_o   = out_s.tvalid;
    assign m_tlast_o    = out_s.tlast;
    assign m_tkeep_o    = out_s.tkeep;
    assign out_s.tready = m_tready_i;

    assign req_pad = MAX_SRC'(s_tvalid_i);
    assign grant_o = grant_q;
    assign busy_o  = (state_q == XFER);

    // Arbitration in IDLE, lane steering and packet-end detection in XFER.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        s_tready_o   = '0;
        arb_s.tvalid = 1'b0;
        arb_s.tdata  = s_tdata_i[int'(grant_q)*T_DATA_WIDTH +: T_DATA_WIDTH];
        arb_s.tkeep  = s_tkeep_i[int'(grant_q)*T_KEEP_WIDTH +: T_KEEP_WIDTH];
        arb_s.tlast  = s_tlast_i[grant_q];
        unique case (state_q)
            IDLE: begin
                if (|s_tvalid_i) begin
                    grant_d = GW'(rr_pick(req_pad, 3'(ptr_q), N_SRC));
                    state_d = XFER;
                end
            end
            XFER: begin
                arb_s.tvalid        = s_tvalid_i[grant_q];
                s_tready_o[grant_q] = arb_s.tready;
                if (s_tvalid_i[grant_q] && arb_s.tready
                    && s_tlast_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = GW'((32'(grant_q) + 1) % N_SRC);
                end
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
